// File: rtl/cas_player.sv
// Cassette tape player: serialises loader bytes LSB first as a square wave,
// one full cycle per bit at 2400 Hz ("1") or 1200 Hz ("0"), pausable by the motor relay.
module cas_player #(
  parameter int unsigned HALF_1 = 11932,
  parameter int unsigned HALF_0 = 23863
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        motor,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        casdout,
  output logic        playing,
  output logic        underrun,
  output logic [15:0] bytes_sent
);

  // Handshake: a byte moves into the holding register on every clk edge where
  // byte_valid and byte_ready are both 1; byte_ready is simply "holding register empty".

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2
  } state_e;

  // Counter is loaded with half-1 so each half-period spans exactly HALF_x cycles.
  localparam logic [14:0] RELOAD_1 = 15'(HALF_1 - 1);
  localparam logic [14:0] RELOAD_0 = 15'(HALF_0 - 1);

  function automatic logic [14:0] reload(input logic b);
    return b ? RELOAD_1 : RELOAD_0;
  endfunction

  state_e      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  holding_q, holding_d;
  logic        holding_full_q, holding_full_d;
  logic        casdout_q, casdout_d;
  logic        underrun_q, underrun_d;
  logic [15:0] bytes_sent_q, bytes_sent_d;
  logic        load_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      holding_q      <= '0;
      holding_full_q <= 1'b0;
      casdout_q      <= 1'b0;
      underrun_q     <= 1'b0;
      bytes_sent_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      holding_q      <= holding_d;
      holding_full_q <= holding_full_d;
      casdout_q      <= casdout_d;
      underrun_q     <= underrun_d;
      bytes_sent_q   <= bytes_sent_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    holding_d      = holding_q;
    holding_full_d = holding_full_q;
    casdout_d      = casdout_q;
    underrun_d     = 1'b0;
    bytes_sent_d   = bytes_sent_q;
    load_next      = 1'b0;

    // Acceptance keeps running while the motor is off.
    if (byte_valid && !holding_full_q) begin
      holding_d      = byte_data;
      holding_full_d = 1'b1;
    end

    if (motor) begin
      case (state_q)
        IDLE: begin
          if (holding_full_q) load_next = 1'b1;
        end
        BIT_HI: begin
          if (cnt_q == 15'd0) begin
            casdout_d = 1'b0;
            cnt_d     = reload(shift_q[0]);
            state_d   = BIT_LO;
          end else begin
            cnt_d = cnt_q - 15'd1;
          end
        end
        BIT_LO: begin
          if (cnt_q == 15'd0) begin
            if (bit_idx_q != 3'd7) begin
              shift_d   = {1'b0, shift_q[7:1]};
              bit_idx_d = bit_idx_q + 3'd1;
              casdout_d = 1'b1;
              cnt_d     = reload(shift_q[1]);
              state_d   = BIT_HI;
            end else begin
              bytes_sent_d = bytes_sent_q + 16'd1;
              if (holding_full_q) begin
                load_next = 1'b1;
              end else begin
                state_d    = IDLE;
                casdout_d  = 1'b0;
                underrun_d = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q - 15'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Shared by IDLE start and the back-to-back path so both load identically.
    if (load_next) begin
      shift_d        = holding_q;
      holding_full_d = 1'b0;
      bit_idx_d      = 3'd0;
      cnt_d          = reload(holding_q[0]);
      casdout_d      = 1'b1;
      state_d        = BIT_HI;
    end
  end

  always_comb begin
    playing    = (state_q == BIT_HI) || (state_q == BIT_LO);
    byte_ready = ~holding_full_q;
    casdout    = casdout_q;
    underrun   = underrun_q;
    bytes_sent = bytes_sent_q;
  end

endmodule

// File: tb/tb_cas_player.sv
// Bench for cas_player with short half-periods: a negedge monitor decodes the
// waveform into bytes, and the test compares them against an expected-byte queue.
module tb_cas_player;

  localparam int H1 = 4;
  localparam int H0 = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        motor = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        casdout;
  logic        playing;
  logic        underrun;
  logic [15:0] bytes_sent;

  always #5 clk = ~clk;

  cas_player #(.HALF_1(H1), .HALF_0(H0)) dut (
    .clk        (clk),
    .reset      (reset),
    .motor      (motor),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .casdout    (casdout),
    .playing    (playing),
    .underrun   (underrun),
    .bytes_sent (bytes_sent)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         rd_idx = 0;

  // Monitor state (written only by the monitor process)
  int         cyc = 0;
  int         mon_err = 0;
  int         n_under = 0;
  int         under_cycles = 0;
  logic [7:0] got_q[$];
  logic       prev_c = 1'b0;
  logic       under_prev = 1'b0;
  logic       lo_pending = 1'b0;
  int         run_len = 0;
  int         hi_len = 0;
  int         nbits = 0;
  logic [7:0] sh = 8'h00;

  // Half-period lengths count only cycles the motor let the DUT advance.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (underrun === 1'b1) begin
        under_cycles++;
        if (!under_prev) n_under++;
      end
      under_prev = (underrun === 1'b1);
      if (reset !== 1'b1) begin
        run_len = 0; hi_len = 0; nbits = 0; lo_pending = 1'b0; prev_c = 1'b0;
      end else begin
        if (motor === 1'b1) begin
          if (casdout !== prev_c) begin
            if (casdout === 1'b1) begin
              if (lo_pending) mon_err++;
              lo_pending = 1'b0;
            end else begin
              hi_len = run_len;
              lo_pending = 1'b1;
            end
            run_len = 1;
          end else begin
            run_len++;
          end
          if (casdout === 1'b0 && lo_pending && run_len == hi_len) begin
            lo_pending = 1'b0;
            if (hi_len != H1 && hi_len != H0) mon_err++;
            sh = {(hi_len == H1), sh[7:1]};
            nbits++;
            if (nbits == 8) begin
              got_q.push_back(sh);
              nbits = 0;
            end
          end
        end
        prev_c = casdout;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    int k = 0;
    while (byte_ready !== 1'b1 && k < 2000) begin
      tick();
      k++;
    end
    check("push_ready", 32'(byte_ready), 32'd1);
    byte_data  = d;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic wait_rise(output int t);
    int k = 0;
    while (casdout !== 1'b1 && k < 2000) begin
      tick();
      k++;
    end
    check("start_rise", 32'(casdout), 32'd1);
    t = cyc;
  endtask

  task automatic wait_underrun(output int t);
    int k = 0;
    tick();
    while (underrun !== 1'b1 && k < 3000) begin
      tick();
      k++;
    end
    check("underrun_seen", 32'(underrun), 32'd1);
    t = cyc;
  endtask

  task automatic drain();
    check("nbytes", 32'(got_q.size() - rd_idx), 32'(exp_q.size()));
    while (rd_idx < got_q.size() && exp_q.size() > 0) begin
      check("byte", 32'(got_q[rd_idx]), 32'(exp_q.pop_front()));
      rd_idx++;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         dur;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   t0, t1, u0, uc0, exp_sent;
    logic bad;

    // Byte duration = sum over bits of 2*H1 ("1") or 2*H0 ("0").
    vecs[0] = '{8'h01, 120};
    vecs[1] = '{8'hFF, 64};
    vecs[2] = '{8'h00, 128};
    vecs[3] = '{8'hA5, 96};
    vecs[4] = '{8'h3C, 96};
    vecs[5] = '{8'h80, 120};
    exp_sent = 0;

    reset = 1'b0;
    motor = 1'b1;
    repeat (3) tick();
    check("rst_casdout", 32'(casdout), 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_bytes_sent", 32'(bytes_sent), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      uc0 = under_cycles;
      push_byte(vecs[i].data);
      wait_rise(t0);
      wait_underrun(t1);
      exp_sent++;
      check("vec_duration", 32'(t1 - t0), 32'(vecs[i].dur));
      check("vec_bytes_sent", 32'(bytes_sent), 32'(exp_sent));
      check("vec_idle_casdout", 32'(casdout), 32'd0);
      check("vec_idle_playing", 32'(playing), 32'd0);
      tick();
      check("vec_underrun_width", 32'(under_cycles - uc0), 32'd1);
      drain();
    end

    // Back-to-back bytes: no gap, one underrun at the very end
    u0 = n_under;
    push_byte(8'hFF);
    wait_rise(t0);
    push_byte(8'h00);
    wait_underrun(t1);
    check("b2b_duration", 32'(t1 - t0), 32'd192);
    repeat (20) tick();
    check("b2b_underruns", 32'(n_under - u0), 32'd1);
    exp_sent += 2;
    check("b2b_bytes_sent", 32'(bytes_sent), 32'(exp_sent));
    drain();

    // Pause for 10 cycles in the low half of bit 1
    push_byte(8'h01);
    wait_rise(t0);
    while (cyc < t0 + 18) tick();
    motor = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (casdout !== 1'b0) bad = 1'b1;
    end
    check("pause_casdout_held", 32'(bad), 32'd0);
    check("pause_playing", 32'(playing), 32'd1);
    motor = 1'b1;
    wait_underrun(t1);
    check("pause_duration", 32'(t1 - t0), 32'd130);
    exp_sent++;
    check("pause_bytes_sent", 32'(bytes_sent), 32'(exp_sent));
    drain();

    // Motor off with a held byte: nothing plays until the motor rises
    motor = 1'b0;
    push_byte(8'hA5);
    repeat (30) tick();
    check("motoroff_byte_ready", 32'(byte_ready), 32'd0);
    check("motoroff_casdout", 32'(casdout), 32'd0);
    check("motoroff_playing", 32'(playing), 32'd0);
    check("motoroff_bytes_sent", 32'(bytes_sent), 32'(exp_sent));
    motor = 1'b1;
    tick();
    check("motoron_casdout", 32'(casdout), 32'd1);
    check("motoron_playing", 32'(playing), 32'd1);
    t0 = cyc;
    wait_underrun(t1);
    check("motoron_duration", 32'(t1 - t0), 32'd96);
    exp_sent++;
    check("motoron_bytes_sent", 32'(bytes_sent), 32'(exp_sent));
    drain();

    // Reset mid-bit with a second byte held
    u0 = n_under;
    push_byte(8'h3C);
    wait_rise(t0);
    repeat (13) tick();
    push_byte(8'h80);
    check("held_byte_ready", 32'(byte_ready), 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_casdout", 32'(casdout), 32'd0);
    check("midrst_byte_ready", 32'(byte_ready), 32'd1);
    check("midrst_bytes_sent", 32'(bytes_sent), 32'd0);
    check("midrst_playing", 32'(playing), 32'd0);
    repeat (300) tick();
    check("midrst_no_underrun", 32'(n_under - u0), 32'd0);
    check("midrst_still_idle", 32'(casdout), 32'd0);
    exp_q.delete();
    rd_idx = got_q.size();
    exp_sent = 0;

    // bytes_sent wraps from 0xFFFF to 0x0000
    force dut.bytes_sent_d = 16'hFFFF;
    tick();
    release dut.bytes_sent_d;
    tick();
    check("wrap_preload", 32'(bytes_sent), 32'h0000_FFFF);
    push_byte(8'h00);
    wait_rise(t0);
    wait_underrun(t1);
    check("wrap_duration", 32'(t1 - t0), 32'd128);
    check("wrap_bytes_sent", 32'(bytes_sent), 32'd0);
    drain();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("waveform_errors", 32'(mon_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cas_player.md
CAS_PLAYER -- requirements
Module: cas_player

Interface
REQ-001 The block SHALL have parameter HALF_1, default 11932, giving the clk cycles per half-period of a "1" bit (2400 Hz at 57.272 MHz).
REQ-002 The block SHALL have parameter HALF_0, default 23863, giving the clk cycles per half-period of a "0" bit (1200 Hz at 57.272 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, 57.272 MHz.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port motor, input, 1 bit: cassette relay (PIA1 CA2); 1 = play, 0 = pause.
REQ-006 The block SHALL have port byte_data, input, 8 bits: next tape byte from the loader.
REQ-007 The block SHALL have port byte_valid, input, 1 bit: byte_data is valid.
REQ-008 The block SHALL have port byte_ready, output, 1 bit: the holding register is empty.
REQ-009 The block SHALL have port casdout, output, 1 bit: square-wave tape signal to PIA1 port A bit 0.
REQ-010 The block SHALL have port playing, output, 1 bit: the FSM is in BIT_HI or BIT_LO.
REQ-011 The block SHALL have port underrun, output, 1 bit: one-cycle pulse when a byte finishes and no next byte is held.
REQ-012 The block SHALL have port bytes_sent, output, 16 bits: count of completed bytes.

Function
REQ-013 Handshake: a byte SHALL be accepted into the holding register on any cycle with byte_valid=1 and byte_ready=1; byte_ready SHALL equal ~holding_full, registered.
REQ-014 FSM states SHALL be IDLE, BIT_HI and BIT_LO, with a 3-bit bit index, an 8-bit shift register and a 15-bit down-counter.
REQ-015 IDLE: when motor=1 and holding_full=1, on that edge the block SHALL do all of the following: shift<=holding, holding_full<=0, bit index<=0, counter<=half(shift[0])-1, casdout<=1, state<=BIT_HI.
REQ-016 half(b) SHALL be HALF_1 when b=1 and HALF_0 when b=0; bits SHALL be sent LSB first.
REQ-017 BIT_HI with counter=0: casdout<=0, counter reloaded with the same half(), state<=BIT_LO.
REQ-018 BIT_LO with counter=0 and bit index<7: shift right, bit index+1, casdout<=1, counter<=half(next bit)-1, state<=BIT_HI.
REQ-019 BIT_LO with counter=0 and bit index=7: bytes_sent SHALL increment, wrapping modulo 2^16.
REQ-020 After REQ-019: if holding_full=1 the next byte SHALL load exactly as in REQ-015 (back-to-back, no gap cycle); otherwise state<=IDLE, casdout<=0 and underrun pulses for 1 cycle.
REQ-021 Each half-period SHALL last exactly HALF_x cycles; a "1" bit SHALL be 2*HALF_1 cycles and a "0" bit 2*HALF_0 cycles.
REQ-022 Pause: while motor=0, the counter, state, bit index, shift register and casdout SHALL be frozen; playback SHALL resume on the first cycle motor=1 with no lost or extra cycles.
REQ-023 While motor=0, byte acceptance into the holding register SHALL continue.
REQ-024 IDLE with motor=0: no load; casdout SHALL stay 0.
REQ-025 A byte accepted on the same cycle the holding register transfers to shift is impossible by construction (byte_ready=0 while full); byte_ready SHALL rise the cycle after the transfer.
REQ-026 playing SHALL be combinational from state; underrun SHALL be registered.

Reset
REQ-027 On the clk edge with reset=0: state=IDLE, casdout=0, holding_full=0 (byte_ready=1 next cycle), underrun=0, bytes_sent=0, counter=0, bit index=0, shift=0.
REQ-028 Reset SHALL take priority over every other event, including mid-bit; a held byte SHALL be discarded.

Verification (HALF_1=4, HALF_0=8)
REQ-029 Reset with motor=1, push 0x01 -> casdout 1 for 4 cycles, 0 for 4 cycles, then seven "0" bits of 8 high/8 low cycles; bytes_sent=1; underrun pulses once; state returns to IDLE.
REQ-030 Push 0xFF then 0x00 while the first byte plays -> 64 cycles of 1-bit waves then 128 cycles of 0-bit waves, no gap cycle; bytes_sent=2; a single underrun at the end.
REQ-031 motor=0 for 10 cycles in the middle of a BIT_LO half -> casdout held at 0; the total byte duration is 10 cycles longer than nominal; the waveform is otherwise identical.
REQ-032 motor=0, push 0xA5 -> byte_ready=0 and casdout=0 indefinitely; raise motor -> playback starts the next cycle with casdout=1.
REQ-033 Assert reset mid-bit with a held byte -> casdout=0, byte_ready=1, bytes_sent=0, no underrun pulse.
REQ-034 Preload bytes_sent to 0xFFFF via 65535 bytes (or force) and complete one byte -> bytes_sent=0x0000.
